bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word address width of the shared BRAM port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter WE_WIDTH, default 4, byte-enable width (DATA_WIDTH/8).
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports reqN_valid in 1, reqN_ready out 1, reqN_addr in ADDR_WIDTH, reqN_wstrb in WE_WIDTH, reqN_wdata in DATA_WIDTH, for N=0,1; request channel.
REQ-007 SHALL have ports respN_valid out 1, respN_ready in 1, respN_data out DATA_WIDTH, for N=0,1; response channel.
REQ-008 SHALL have ports bram_en out 1, bram_we out WE_WIDTH, bram_addr out ADDR_WIDTH, bram_di out DATA_WIDTH, bram_do in DATA_WIDTH; drives one non-pipelined write-first BRAM port.

Function
REQ-009 SHALL share one BRAM port between two requesters; a transfer occurs when reqN_valid and reqN_ready are both 1.
REQ-010 SHALL hold states IDLE, FLIGHT (access issued last cycle, bram_do valid now), HOLD (response buffered, awaiting respN_ready).
REQ-011 SHALL issue (assert reqN_ready for the granted port, bram_en=1, drive addr/wstrb/wdata to BRAM) only in IDLE, or in FLIGHT when the in-flight response is accepted that same cycle; never in HOLD.
REQ-012 SHALL grant round-robin: if both valid, grant the port not granted most recently; if one valid, grant it; last-grant pointer updates only on a grant.
REQ-013 SHALL treat wstrb=0 as read, nonzero as byte-masked write; every request, read or write, produces exactly one response.
REQ-014 SHALL, in FLIGHT, assert resp{owner}_valid with resp{owner}_data=bram_do; 1-cycle latency from grant to response valid.
REQ-015 SHALL, in FLIGHT with resp{owner}_ready=0, capture bram_do into the hold register and enter HOLD; resp{owner}_data then comes from the hold register.
REQ-016 SHALL leave HOLD for IDLE on resp{owner}_ready=1; next grant earliest the following cycle.
REQ-017 SHALL keep the non-owner respN_valid=0 at all times; responses return in issue order.
REQ-018 SHALL sustain one access per cycle for back-to-back traffic with resp_ready held 1.
REQ-019 SHALL drive bram_en=0, bram_we=0 when no grant; bram_addr/bram_di don't-care then.
REQ-020 SHALL permit combinational reqN_ready dependence on reqN_valid, respN_ready and state; no combinational path from bram_do to any ready.

Reset
REQ-021 SHALL, while RST_N=0: state IDLE, last-grant pointer=1 (port 0 wins first tie), hold register 0, all ready/valid outputs 0, bram_en=0, bram_we=0.
REQ-022 SHALL drop any in-flight or held response on reset mid-operation; no response emitted after release.

Configuration
REQ-023 SHALL, with BRAM_ARB_FIXED_PRIO_EN defined, grant port 0 whenever req0_valid=1 (fixed priority, pointer unused); without it, round-robin per REQ-012.

Structure
REQ-024 SHALL place state enum (IDLE/FLIGHT/HOLD) and owner-id typedef in package bram_arb_pkg.
REQ-025 SHALL implement the grant decision in sub-module bram_arb_pick (2-way round-robin/fixed-priority picker).

Verification
REQ-026 SHALL cover: reset, port0 write addr 0x10 wstrb 0xF data 0xDEADBEEF, then read 0x10 -> write resp 0xDEADBEEF, read resp 0xDEADBEEF, each 1 cycle after grant.
REQ-027 SHALL cover: both ports valid 6 consecutive cycles, resp_ready=1 -> grants alternate 0,1,0,1,0,1, bram_en=1 every cycle.
REQ-028 SHALL cover: resp1_ready=0 for 3 cycles after port1 read of 0x20 holding 0x12345678 -> HOLD, resp1_data stable 0x12345678, bram_en=0, req0_ready=0 until accept.
REQ-029 SHALL cover: partial write wstrb 0x2 data 0x0000AB00 to word 0x11223344 -> response and later read 0x1122AB44.
REQ-030 SHALL cover: RST_N asserted in HOLD -> all outputs 0 asynchronously, no response after release, first tie grants port 0.
REQ-031 SHALL cover: build with BRAM_ARB_FIXED_PRIO_EN, both valid 4 cycles -> port 0 granted all 4, port 1 only after req0_valid drops.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types for the two-port BRAM arbiter.
// State encoding of the access sequencer and the requester identifier.
package bram_arb_pkg;

   // Sequencer states: nothing outstanding / read data on bram_do now /
   // response parked in the hold register waiting for the owner.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      HOLD   = 2'd2
   } arb_state_e;

   // Identifier of a requester port (0 or 1).
   typedef logic [0:0] owner_t;

   localparam owner_t OWNER_P0 = 1'b0;
   localparam owner_t OWNER_P1 = 1'b1;

   // The port that is not the given one; used for round-robin alternation.
   function automatic owner_t other_owner(input owner_t id);
      return owner_t'(~id);
   endfunction

endpackage : bram_arb_pkg

// File: rtl/bram_arb_pick.sv
// bram_arb_pick: two-way grant picker for bram_port_arbiter.
// Default build is round-robin on ties (favour the port not granted most
// recently). Define BRAM_ARB_FIXED_PRIO_EN for fixed priority to port 0,
// in which case the last-grant input is ignored.
module bram_arb_pick
   import bram_arb_pkg::*;
(
   input  logic   req0_valid,
   input  logic   req1_valid,
   input  owner_t last_grant,
   output logic   gnt_valid,
   output owner_t gnt_id
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
   // The pointer still exists in the parent; fixed priority does not need it.
   logic unused_last_s;
   assign unused_last_s = last_grant[0];

   // Fixed priority: port 0 wins whenever it is asking.
   always_comb begin
      gnt_valid = req0_valid | req1_valid;
      gnt_id    = OWNER_P0;
      if (req0_valid) begin
         gnt_id = OWNER_P0;
      end else if (req1_valid) begin
         gnt_id = OWNER_P1;
      end else begin
         gnt_id = OWNER_P0;
      end
   end
`else
   // Round-robin: on a tie grant the port that lost last time.
   always_comb begin
      gnt_valid = req0_valid | req1_valid;
      gnt_id    = OWNER_P0;
      if (req0_valid && req1_valid) begin
         gnt_id = other_owner(last_grant);
      end else if (req1_valid) begin
         gnt_id = OWNER_P1;
      end else begin
         gnt_id = OWNER_P0;
      end
   end
`endif

endmodule : bram_arb_pick

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one non-pipelined, write-first BRAM port between
// two valid/ready requesters. At most one access is outstanding; its response
// is presented the cycle after the grant straight from bram_do and is parked
// in a hold register if the owning port is not ready to take it.
// Build option: BRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead
// of round-robin (implemented in bram_arb_pick).
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int WE_WIDTH   = 4
)(
   input  logic                  CLK,
   input  logic                  RST_N,
   // requester 0
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [WE_WIDTH-1:0]   req0_wstrb,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  resp0_valid,
   input  logic                  resp0_ready,
   output logic [DATA_WIDTH-1:0] resp0_data,
   // requester 1
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [WE_WIDTH-1:0]   req1_wstrb,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  resp1_valid,
   input  logic                  resp1_ready,
   output logic [DATA_WIDTH-1:0] resp1_data,
   // shared BRAM port
   output logic                  bram_en,
   output logic [WE_WIDTH-1:0]   bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_di,
   input  logic [DATA_WIDTH-1:0] bram_do
);

   arb_state_e            state_r;
   arb_state_e            state_s;
   owner_t                owner_r;
   owner_t                owner_s;
   owner_t                last_r;
   owner_t                last_s;
   logic [DATA_WIDTH-1:0] hold_r;
   logic [DATA_WIDTH-1:0] hold_s;

   logic                  gnt_valid_s;
   owner_t                gnt_id_s;
   logic                  resp_pending_s;
   logic                  owner_ready_s;
   logic                  accept_s;
   logic                  can_issue_s;
   logic                  issue_s;
   logic [DATA_WIDTH-1:0] resp_data_s;

   bram_arb_pick u_pick (
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .last_grant (last_r),
      .gnt_valid  (gnt_valid_s),
      .gnt_id     (gnt_id_s)
   );

   // Response side: is a response owed, where its data comes from, is it taken now
   always_comb begin
      resp_pending_s = 1'b0;
      resp_data_s    = bram_do;
      owner_ready_s  = 1'b0;
      case (state_r)
         IDLE: begin
            resp_pending_s = 1'b0;
            resp_data_s    = bram_do;
         end
         FLIGHT: begin
            resp_pending_s = 1'b1;
            resp_data_s    = bram_do;
         end
         HOLD: begin
            resp_pending_s = 1'b1;
            resp_data_s    = hold_r;
         end
         default: begin
            resp_pending_s = 1'b0;
            resp_data_s    = hold_r;
         end
      endcase
      if (owner_r == OWNER_P1) begin
         owner_ready_s = resp1_ready;
      end else begin
         owner_ready_s = resp0_ready;
      end
      accept_s = resp_pending_s & owner_ready_s;
   end

   // Issue permission: when idle, or when the in-flight response leaves this cycle
   always_comb begin
      can_issue_s = 1'b0;
      case (state_r)
         IDLE:    can_issue_s = RST_N;
         FLIGHT:  can_issue_s = RST_N & accept_s;
         HOLD:    can_issue_s = 1'b0;
         default: can_issue_s = 1'b0;
      endcase
      issue_s = can_issue_s & gnt_valid_s;
   end

   // Next-state, owner, last-grant pointer and hold-register capture
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      last_s  = last_r;
      hold_s  = hold_r;
      case (state_r)
         IDLE: begin
            if (issue_s) begin
               state_s = FLIGHT;
            end else begin
               state_s = IDLE;
            end
         end
         FLIGHT: begin
            if (accept_s && issue_s) begin
               state_s = FLIGHT;
            end else if (accept_s) begin
               state_s = IDLE;
            end else begin
               // Owner stalled: bram_do is only valid now, so park it.
               state_s = HOLD;
               hold_s  = bram_do;
            end
         end
         HOLD: begin
            if (accept_s) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      if (issue_s) begin
         owner_s = gnt_id_s;
         last_s  = gnt_id_s;
      end else begin
         owner_s = owner_r;
         last_s  = last_r;
      end
   end

   // Sequencer registers; reset drops anything in flight or held
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= IDLE;
         owner_r <= OWNER_P0;
         last_r  <= OWNER_P1;
         hold_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         last_r  <= last_s;
         hold_r  <= hold_s;
      end
   end

   // Drive the BRAM port, request handshakes and response channels
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      bram_en    = issue_s;
      bram_we    = {WE_WIDTH{1'b0}};
      bram_addr  = req0_addr;
      bram_di    = req0_wdata;
      if (gnt_id_s == OWNER_P1) begin
         bram_addr  = req1_addr;
         bram_di    = req1_wdata;
         req1_ready = issue_s;
         if (issue_s) begin
            bram_we = req1_wstrb;
         end else begin
            bram_we = {WE_WIDTH{1'b0}};
         end
      end else begin
         bram_addr  = req0_addr;
         bram_di    = req0_wdata;
         req0_ready = issue_s;
         if (issue_s) begin
            bram_we = req0_wstrb;
         end else begin
            bram_we = {WE_WIDTH{1'b0}};
         end
      end
      resp0_valid = resp_pending_s & (owner_r == OWNER_P0);
      resp1_valid = resp_pending_s & (owner_r == OWNER_P1);
      resp0_data  = resp_data_s;
      resp1_data  = resp_data_s;
   end

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (memory array + one pending response).
// The BRAM is modelled as write-first, one-cycle read; its output is random
// whenever it is not enabled so only a held copy can keep data stable.
module tb_bram_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int WW = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          req0_valid, req0_ready, resp0_valid, resp0_ready;
   logic          req1_valid, req1_ready, resp1_valid, resp1_ready;
   logic [AW-1:0] req0_addr, req1_addr, bram_addr;
   logic [WW-1:0] req0_wstrb, req1_wstrb, bram_we;
   logic [DW-1:0] req0_wdata, req1_wdata, resp0_data, resp1_data, bram_di, bram_do;
   logic          bram_en;

   int n_cmp = 0;
   int n_bad = 0;

   bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_wstrb(req0_wstrb), .req0_wdata(req0_wdata),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_di(bram_di), .bram_do(bram_do)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] mem [0:255] = '{default: 32'h0};

   // Write-first BRAM: data out is the post-write word; garbage when idle
   always @(posedge CLK) begin : bram_model
      logic [DW-1:0] w;
      if (bram_en) begin
         w = mem[bram_addr[7:0]];
         for (int b = 0; b < WW; b++)
            if (bram_we[b]) w[8*b +: 8] = bram_di[8*b +: 8];
         mem[bram_addr[7:0]] <= w;
         bram_do <= w;
      end else begin
         bram_do <= $urandom;
      end
   end

   // Hard bound on total run time
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic next_cycle(); @(posedge CLK); #1; endtask
   task automatic settle(); #3; endtask

   task automatic set_req(input int p, input logic v, input logic [AW-1:0] a,
                          input logic [WW-1:0] s, input logic [DW-1:0] d);
      if (p == 0) begin
         req0_valid = v; req0_addr = a; req0_wstrb = s; req0_wdata = d;
      end else begin
         req1_valid = v; req1_addr = a; req1_wstrb = s; req1_wdata = d;
      end
   endtask

   task automatic idle_inputs();
      set_req(0, 1'b0, 16'h0000, 4'h0, 32'h0);
      set_req(1, 1'b0, 16'h0000, 4'h0, 32'h0);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #5 RST_N = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      set_req(0, 1'b1, 16'h0001, 4'h0, 32'h0);
      set_req(1, 1'b1, 16'h0002, 4'h0, 32'h0);
      @(posedge CLK); #1; settle();
      n_cmp++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, bram_en, bram_we} !== 9'h000) begin n_bad++; $display("FAIL reset_outputs got=%h exp=%h", {req0_ready, req1_ready, resp0_valid, resp1_valid, bram_en, bram_we}, 9'h000); end
      do_reset();
   endtask

   task automatic test_write_read();
      do_reset();
      set_req(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF); settle();
      n_cmp++; if ({req0_ready, bram_en, bram_we} !== 6'b11_1111) begin n_bad++; $display("FAIL wr_issue got=%b exp=%b", {req0_ready, bram_en, bram_we}, 6'b11_1111); end
      n_cmp++; if ({bram_addr, bram_di} !== {16'h0010, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_bus got=%h exp=%h", {bram_addr, bram_di}, {16'h0010, 32'hDEADBEEF}); end
      next_cycle();
      set_req(0, 1'b1, 16'h0010, 4'h0, 32'h0); settle();
      n_cmp++; if ({resp0_valid, resp0_data} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_resp got=%h exp=%h", {resp0_valid, resp0_data}, {1'b1, 32'hDEADBEEF}); end
      n_cmp++; if ({req0_ready, bram_en, bram_we} !== 6'b11_0000) begin n_bad++; $display("FAIL rd_issue got=%b exp=%b", {req0_ready, bram_en, bram_we}, 6'b11_0000); end
      next_cycle();
      set_req(0, 1'b0, 16'h0000, 4'h0, 32'h0); settle();
      n_cmp++; if ({resp0_valid, resp1_valid, resp0_data} !== {2'b10, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rd_resp got=%h exp=%h", {resp0_valid, resp1_valid, resp0_data}, {2'b10, 32'hDEADBEEF}); end
      next_cycle(); settle();
      n_cmp++; if ({resp0_valid, bram_en} !== 2'b00) begin n_bad++; $display("FAIL wr_rd_idle got=%b exp=%b", {resp0_valid, bram_en}, 2'b00); end
   endtask

   task automatic test_back_to_back();
      int exp_g;
      int prev_g;
      do_reset();
      prev_g = -1;
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, 16'h0050 + 16'(i), 4'h0, 32'h0);
         set_req(1, 1'b1, 16'h0058 + 16'(i), 4'h0, 32'h0);
         settle();
`ifdef BRAM_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = i % 2;
`endif
         n_cmp++; if ({req1_ready, req0_ready, bram_en} !== {(exp_g == 1), (exp_g == 0), 1'b1}) begin n_bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {req1_ready, req0_ready, bram_en}, {(exp_g == 1), (exp_g == 0), 1'b1}); end
         if (prev_g >= 0) begin
            n_cmp++; if ({resp1_valid, resp0_valid} !== {(prev_g == 1), (prev_g == 0)}) begin n_bad++; $display("FAIL b2b_resp[%0d] got=%b exp=%b", i, {resp1_valid, resp0_valid}, {(prev_g == 1), (prev_g == 0)}); end
         end
         prev_g = exp_g;
         next_cycle();
      end
      idle_inputs();
      next_cycle(); settle();
      n_cmp++; if ({resp1_valid, resp0_valid, bram_en} !== 3'b000) begin n_bad++; $display("FAIL b2b_drain got=%b exp=%b", {resp1_valid, resp0_valid, bram_en}, 3'b000); end
   endtask

   task automatic test_priority();
      int exp_g;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, 16'h0060, 4'h0, 32'h0);
         set_req(1, 1'b1, 16'h0061, 4'h0, 32'h0);
         settle();
`ifdef BRAM_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = i % 2;
`endif
         n_cmp++; if ({req1_ready, req0_ready} !== {(exp_g == 1), (exp_g == 0)}) begin n_bad++; $display("FAIL prio_grant[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, {(exp_g == 1), (exp_g == 0)}); end
         next_cycle();
      end
      set_req(0, 1'b0, 16'h0000, 4'h0, 32'h0); settle();
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL prio_p1_after got=%b exp=%b", {req1_ready, req0_ready}, 2'b10); end
      next_cycle();
      idle_inputs(); next_cycle();
   endtask

   task automatic test_hold();
      do_reset();
      set_req(1, 1'b1, 16'h0020, 4'hF, 32'h12345678); settle();
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL hold_wr_ready got=%b exp=%b", req1_ready, 1'b1); end
      next_cycle();
      set_req(1, 1'b1, 16'h0020, 4'h0, 32'h0); settle();
      n_cmp++; if ({req1_ready, resp1_valid} !== 2'b11) begin n_bad++; $display("FAIL hold_rd_issue got=%b exp=%b", {req1_ready, resp1_valid}, 2'b11); end
      next_cycle();
      set_req(1, 1'b0, 16'h0000, 4'h0, 32'h0);
      set_req(0, 1'b1, 16'h0040, 4'h0, 32'h0);
      resp1_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_cmp++; if ({resp1_valid, resp0_valid, resp1_data} !== {2'b10, 32'h12345678}) begin n_bad++; $display("FAIL hold_data[%0d] got=%h exp=%h", k, {resp1_valid, resp0_valid, resp1_data}, {2'b10, 32'h12345678}); end
         n_cmp++; if ({bram_en, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL hold_blocked[%0d] got=%b exp=%b", k, {bram_en, req0_ready}, 2'b00); end
         next_cycle();
      end
      resp1_ready = 1'b1; settle();
      n_cmp++; if ({resp1_valid, resp1_data, req0_ready, bram_en} !== {1'b1, 32'h12345678, 2'b00}) begin n_bad++; $display("FAIL hold_accept got=%h exp=%h", {resp1_valid, resp1_data, req0_ready, bram_en}, {1'b1, 32'h12345678, 2'b00}); end
      next_cycle(); settle();
      n_cmp++; if ({resp1_valid, req0_ready, bram_en} !== 3'b011) begin n_bad++; $display("FAIL hold_release got=%b exp=%b", {resp1_valid, req0_ready, bram_en}, 3'b011); end
      next_cycle();
      set_req(0, 1'b0, 16'h0000, 4'h0, 32'h0); settle();
      n_cmp++; if ({resp0_valid, resp1_valid, resp0_data} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL hold_p0_resp got=%h exp=%h", {resp0_valid, resp1_valid, resp0_data}, {2'b10, 32'h0}); end
      next_cycle();
   endtask

   task automatic test_partial();
      do_reset();
      set_req(0, 1'b1, 16'h0030, 4'hF, 32'h11223344); settle();
      n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL part_full_ready got=%b exp=%b", req0_ready, 1'b1); end
      next_cycle();
      set_req(0, 1'b1, 16'h0030, 4'h2, 32'h0000AB00); settle();
      n_cmp++; if ({req0_ready, bram_we, resp0_valid, resp0_data} !== {1'b1, 4'h2, 1'b1, 32'h11223344}) begin n_bad++; $display("FAIL part_issue got=%h exp=%h", {req0_ready, bram_we, resp0_valid, resp0_data}, {1'b1, 4'h2, 1'b1, 32'h11223344}); end
      next_cycle();
      set_req(0, 1'b1, 16'h0030, 4'h0, 32'h0); settle();
      n_cmp++; if ({resp0_valid, resp0_data} !== {1'b1, 32'h1122AB44}) begin n_bad++; $display("FAIL part_wr_resp got=%h exp=%h", {resp0_valid, resp0_data}, {1'b1, 32'h1122AB44}); end
      next_cycle();
      set_req(0, 1'b0, 16'h0000, 4'h0, 32'h0); settle();
      n_cmp++; if ({resp0_valid, resp0_data} !== {1'b1, 32'h1122AB44}) begin n_bad++; $display("FAIL part_rd_resp got=%h exp=%h", {resp0_valid, resp0_data}, {1'b1, 32'h1122AB44}); end
      next_cycle();
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      resp1_ready = 1'b0;
      set_req(1, 1'b1, 16'h0020, 4'h0, 32'h0); settle();
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL rih_issue got=%b exp=%b", req1_ready, 1'b1); end
      next_cycle();
      set_req(1, 1'b0, 16'h0000, 4'h0, 32'h0);
      next_cycle(); settle();
      n_cmp++; if (resp1_valid !== 1'b1) begin n_bad++; $display("FAIL rih_held got=%b exp=%b", resp1_valid, 1'b1); end
      RST_N = 1'b0; #1;
      n_cmp++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, bram_en, bram_we} !== 9'h000) begin n_bad++; $display("FAIL rih_async got=%h exp=%h", {req0_ready, req1_ready, resp0_valid, resp1_valid, bram_en, bram_we}, 9'h000); end
      set_req(0, 1'b1, 16'h0070, 4'h0, 32'h0);
      set_req(1, 1'b1, 16'h0071, 4'h0, 32'h0);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      @(posedge CLK); #5 RST_N = 1'b1; #2;
      n_cmp++; if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0010) begin n_bad++; $display("FAIL rih_release got=%b exp=%b", {resp0_valid, resp1_valid, req0_ready, req1_ready}, 4'b0010); end
      next_cycle();
      idle_inputs(); settle();
      n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b10) begin n_bad++; $display("FAIL rih_first_resp got=%b exp=%b", {resp0_valid, resp1_valid}, 2'b10); end
      next_cycle(); settle();
      n_cmp++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_bad++; $display("FAIL rih_no_stale got=%b exp=%b", {resp0_valid, resp1_valid}, 2'b00); end
   endtask

   task automatic test_random();
      logic [DW-1:0] ref_mem [0:7];
      logic          v [2];
      logic          rr [2];
      logic [AW-1:0] a [2];
      logic [WW-1:0] s [2];
      logic [DW-1:0] d [2];
      logic          pend_vld, pend_fresh, accept, can_issue, issue;
      logic [DW-1:0] pend_data, word;
      logic [WW-1:0] exp_we;
      int            pend_port, last, win;
      for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
      do_reset();
      pend_vld = 1'b0; pend_fresh = 1'b0; pend_port = 0; pend_data = 32'h0; last = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            v[p]  = ($urandom_range(0, 9) < 7);
            rr[p] = ($urandom_range(0, 3) != 0);
            a[p]  = 16'h0080 + 16'($urandom_range(0, 7));
            s[p]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d[p]  = $urandom;
         end
         set_req(0, v[0], a[0], s[0], d[0]);
         set_req(1, v[1], a[1], s[1], d[1]);
         resp0_ready = rr[0]; resp1_ready = rr[1];
         settle();
         accept    = pend_vld && rr[pend_port];
         can_issue = !pend_vld || (pend_fresh && accept);
         win = -1;
         if (can_issue) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            if (v[0]) win = 0; else if (v[1]) win = 1;
`else
            if (v[0] && v[1]) win = 1 - last; else if (v[0]) win = 0; else if (v[1]) win = 1;
`endif
         end
         issue  = (win >= 0);
         exp_we = issue ? s[win] : 4'h0;
         n_cmp++; if ({req1_ready, req0_ready, bram_en} !== {(win == 1), (win == 0), issue}) begin n_bad++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", cyc, {req1_ready, req0_ready, bram_en}, {(win == 1), (win == 0), issue}); end
         n_cmp++; if (bram_we !== exp_we) begin n_bad++; $display("FAIL rnd_we[%0d] got=%h exp=%h", cyc, bram_we, exp_we); end
         if (issue) begin
            n_cmp++; if ({bram_addr, bram_di} !== {a[win], d[win]}) begin n_bad++; $display("FAIL rnd_bus[%0d] got=%h exp=%h", cyc, {bram_addr, bram_di}, {a[win], d[win]}); end
         end
         n_cmp++; if ({resp1_valid, resp0_valid} !== {(pend_vld && pend_port == 1), (pend_vld && pend_port == 0)}) begin n_bad++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", cyc, {resp1_valid, resp0_valid}, {(pend_vld && pend_port == 1), (pend_vld && pend_port == 0)}); end
         if (pend_vld) begin
            n_cmp++; if (((pend_port == 1) ? resp1_data : resp0_data) !== pend_data) begin n_bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", cyc, ((pend_port == 1) ? resp1_data : resp0_data), pend_data); end
         end
         if (accept) pend_vld = 1'b0;
         else if (pend_vld) pend_fresh = 1'b0;
         if (issue) begin
            word = ref_mem[a[win][2:0]];
            for (int b = 0; b < WW; b++)
               if (s[win][b]) word[8*b +: 8] = d[win][8*b +: 8];
            ref_mem[a[win][2:0]] = word;
            pend_vld = 1'b1; pend_fresh = 1'b1; pend_port = win; pend_data = word;
            last = win;
         end
         next_cycle();
      end
      idle_inputs();
      repeat (3) next_cycle();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_priority();
      test_hold();
      test_partial();
      test_reset_in_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bram_port_arbiter
